// File: rtl/calc2_pkg.sv
// -----------------------------------------------------------------------------
// calc2_pkg
// Shared types for the calc2 port responder: command and response encodings,
// the queued request record, and the pure arithmetic used by the execute unit.
// No ports (package).
// -----------------------------------------------------------------------------
package calc2_pkg;

    typedef enum logic [3:0] {
        NOOP    = 4'd0,
        ADD     = 4'd1,
        SUB     = 4'd2,
        SHLEFT  = 4'd5,
        SHRIGHT = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_OK   = 2'b01,
        RESP_ERR  = 2'b10
    } resp_e;

    // cmd is kept as raw bits so that unsupported opcodes survive the FIFO
    // and can be answered with an error response.
    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  tag;
    } req_s;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } result_s;

    // Result of one command. Error responses always carry zero data.
    function automatic result_s calc_exec(req_s r);
        result_s     res;
        logic [32:0] sum;
        res.resp = RESP_ERR;
        res.data = '0;
        sum      = {1'b0, r.op1} + {1'b0, r.op2};
        case (r.cmd)
            ADD: begin
                if (!sum[32]) begin
                    res.resp = RESP_OK;
                    res.data = sum[31:0];
                end
            end
            SUB: begin
                if (r.op2 <= r.op1) begin
                    res.resp = RESP_OK;
                    res.data = r.op1 - r.op2;
                end
            end
            SHLEFT: begin
                res.resp = RESP_OK;
                res.data = r.op1 << r.op2[4:0];
            end
            SHRIGHT: begin
                res.resp = RESP_OK;
                res.data = r.op1 >> r.op2[4:0];
            end
            default: begin
                res.resp = RESP_ERR;
                res.data = '0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/calc2_port_responder_if.sv
// -----------------------------------------------------------------------------
// calc2_port_responder_if
// One calc2 request port plus its response and status signals.
//   req_cmd_in  [3:0]  command (nonzero starts a two-cycle request)
//   req_data_in [31:0] op1 in the command cycle, op2 in the next cycle
//   req_tag_in  [1:0]  tag, taken in the command cycle
//   out_resp    [1:0]  00 none, 01 ok, 10 error; one-cycle pulse
//   out_data    [31:0] result, meaningful only with out_resp=01
//   out_tag     [1:0]  tag of the command being answered
//   busy               work queued or executing
//   drop_err           sticky: a request was lost to a full queue
//
// Handshake: there is no ready signal. A nonzero req_cmd_in while the
// responder is idle is a request; the following cycle always carries op2.
// Requests that find the command queue full are discarded and flagged via
// drop_err. A response is valid for exactly the one cycle out_resp != 00.
// -----------------------------------------------------------------------------
interface calc2_port_responder_if;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        busy;
    logic        drop_err;

    modport master (
        output req_cmd_in, req_data_in, req_tag_in,
        input  out_resp, out_data, out_tag, busy, drop_err
    );

    modport slave (
        input  req_cmd_in, req_data_in, req_tag_in,
        output out_resp, out_data, out_tag, busy, drop_err
    );
endinterface

// File: rtl/calc2_cmd_fifo.sv
// -----------------------------------------------------------------------------
// calc2_cmd_fifo
// Synchronous FIFO of req_s entries with full/empty flags.
//   clk, rst        clock, synchronous active-high reset
//   push, wr_data   write request; ignored when full unless pop is also high
//   pop,  rd_data   read request; rd_data shows the head combinationally
//   full, empty     occupancy flags
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module calc2_cmd_fifo
    import calc2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  req_s wr_data,
    input  logic pop,
    output req_s rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    req_s         mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle;
    // the write lands in the slot being vacated, whose old value is read
    // combinationally before the edge.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/calc2_port_responder.sv
// -----------------------------------------------------------------------------
// calc2_port_responder
// Responder end of one calc2 request port. Captures two-cycle requests,
// queues them, executes ADD/SUB/SHLEFT/SHRIGHT with per-class latency and
// returns one-cycle responses in request order.
//   c_clk      clock, all logic on rising edge
//   reset      synchronous active-high reset; drops all in-flight work
//   port       calc2_port_responder_if.slave (request/response/status)
//   dbg_state  capture FSM state (0 IDLE, 1 WAIT_OP2)
// Parameters: FIFO_DEPTH (power of 2, >=2), ADD_LAT (>=1), SHIFT_LAT (>=1).
// -----------------------------------------------------------------------------
module calc2_port_responder
    import calc2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADD_LAT    = 2,
    parameter int SHIFT_LAT  = 3
) (
    input  logic                    c_clk,
    input  logic                    reset,
    calc2_port_responder_if.slave   port,
    output logic [0:0]              dbg_state
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_OP2 = 1'b1;

    localparam int MAX_LAT = (ADD_LAT > SHIFT_LAT) ? ADD_LAT : SHIFT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // ---------------------------------------------------------------- capture
    logic [0:0]  state;
    logic [3:0]  cap_cmd;
    logic [31:0] cap_op1;
    logic [1:0]  cap_tag;

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cap_cmd <= '0;
            cap_op1 <= '0;
            cap_tag <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (port.req_cmd_in != 4'd0) begin
                        cap_cmd <= port.req_cmd_in;
                        cap_op1 <= port.req_data_in;
                        cap_tag <= port.req_tag_in;
                        state   <= ST_WAIT_OP2;
                    end
                end
                // The op2 cycle always completes the request; any command
                // value present on the bus in this cycle is not looked at.
                ST_WAIT_OP2: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

    // ------------------------------------------------------------------ queue
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    req_s push_data;
    req_s head;

    assign push      = (state == ST_WAIT_OP2);
    assign push_data = '{cmd: cap_cmd, op1: cap_op1,
                         op2: port.req_data_in, tag: cap_tag};

    calc2_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (c_clk),
        .rst     (reset),
        .push    (push),
        .wr_data (push_data),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------------------------------------------------------- execute
    function automatic logic [CNT_W-1:0] lat_for(logic [3:0] cmd);
        logic [CNT_W-1:0] lat;
        case (cmd)
            ADD, SUB:        lat = CNT_W'(ADD_LAT);
            SHLEFT, SHRIGHT: lat = CNT_W'(SHIFT_LAT);
            default:         lat = CNT_W'(1);
        endcase
        return lat;
    endfunction

    logic             active;
    logic [CNT_W-1:0] count;
    req_s             exec_q;
    logic             exec_done;
    result_s          exec_res;

    logic [1:0]       resp_q;
    logic [31:0]      data_q;
    logic [1:0]       tag_q;
    logic             drop_q;

    // count holds the cycles left including the current one; the result is
    // written out on the edge where it reads 1, and that same edge may
    // already start the next queued command.
    assign exec_done = active && (count == CNT_W'(1));
    assign pop       = !fifo_empty && (!active || exec_done);
    assign exec_res  = calc_exec(exec_q);

    always_ff @(posedge c_clk) begin
        if (reset) begin
            active <= 1'b0;
            count  <= '0;
            exec_q <= '0;
            resp_q <= RESP_NONE;
            data_q <= '0;
            tag_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            // Response registers pulse for a single cycle.
            resp_q <= RESP_NONE;
            data_q <= '0;
            tag_q  <= '0;
            if (exec_done) begin
                resp_q <= exec_res.resp;
                data_q <= exec_res.data;
                tag_q  <= exec_q.tag;
            end

            if (pop) begin
                exec_q <= head;
                count  <= lat_for(head.cmd);
                active <= 1'b1;
            end else if (exec_done) begin
                active <= 1'b0;
            end else if (active) begin
                count  <= count - 1'b1;
            end

            if (push && fifo_full && !pop) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign port.out_resp = resp_q;
    assign port.out_data = data_q;
    assign port.out_tag  = tag_q;
    assign port.busy     = !fifo_empty || active;
    assign port.drop_err = drop_q;

endmodule

// File: tb/tb_calc2_port_responder.sv
// -----------------------------------------------------------------------------
// tb_calc2_port_responder
// Two responders share one request stream: dut_a with SHIFT_LAT=3 and dut_b
// with SHIFT_LAT=20, so the same bursts exercise both the no-overflow and
// the overflow paths. A timeline model predicts, per request, the cycle it
// leaves the queue and the cycle its response appears.
// -----------------------------------------------------------------------------
module tb_calc2_port_responder;

    localparam int DEPTH = 4;
    localparam int ADD_L = 2;

    // ------------------------------------------------------ clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc2_port_responder_if bus_a ();
    calc2_port_responder_if bus_b ();
    logic [0:0] dbg_a;
    logic [0:0] dbg_b;

    calc2_port_responder #(.FIFO_DEPTH(DEPTH), .ADD_LAT(ADD_L), .SHIFT_LAT(3)) dut_a (
        .c_clk (clk), .reset (rst), .port (bus_a.slave), .dbg_state (dbg_a)
    );

    calc2_port_responder #(.FIFO_DEPTH(DEPTH), .ADD_LAT(ADD_L), .SHIFT_LAT(20)) dut_b (
        .c_clk (clk), .reset (rst), .port (bus_b.slave), .dbg_state (dbg_b)
    );

    // ------------------------------------------------------ reference model
    typedef struct {
        int          inst;
        int          push;
        int          pop;
        int          done;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } ent_t;

    ent_t ent_q[$];
    int   last_done [2];
    int   drop_at [2];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    function automatic int lat_of(int inst, logic [3:0] cmd);
        if (cmd == 4'd1 || cmd == 4'd2) return ADD_L;
        if (cmd == 4'd5 || cmd == 4'd6) return (inst == 0) ? 3 : 20;
        return 1;
    endfunction

    task automatic ref_result(input logic [3:0] cmd, input logic [31:0] op1,
                              input logic [31:0] op2, output logic [1:0] resp,
                              output logic [31:0] data);
        longint s;
        resp = 2'b10;
        data = 32'd0;
        case (cmd)
            4'd1: begin
                s = longint'(op1) + longint'(op2);
                if (s <= 64'hFFFF_FFFF) begin resp = 2'b01; data = 32'(s); end
            end
            4'd2: if (op1 >= op2) begin resp = 2'b01; data = op1 - op2; end
            4'd5: begin resp = 2'b01; data = op1 << (op2 % 32); end
            4'd6: begin resp = 2'b01; data = op1 >> (op2 % 32); end
            default: begin resp = 2'b10; data = 32'd0; end
        endcase
    endtask

    task automatic model_clear();
        ent_q.delete();
        last_done[0] = 0;
        last_done[1] = 0;
        drop_at[0]   = -1;
        drop_at[1]   = -1;
    endtask

    // Request whose op2 is taken on edge p. It waits in the queue from p
    // until the execute unit is free (never before p+1) and answers lat
    // cycles later. It is lost if DEPTH older requests are still queued
    // after edge p.
    task automatic model_add(input logic [3:0] cmd, input logic [31:0] op1,
                             input logic [31:0] op2, input logic [1:0] tag,
                             input int p);
        for (int k = 0; k < 2; k++) begin
            int   occ;
            ent_t e;
            occ = 0;
            foreach (ent_q[i])
                if (ent_q[i].inst == k && ent_q[i].push < p && ent_q[i].pop > p) occ++;
            if (occ >= DEPTH) begin
                if (drop_at[k] < 0) drop_at[k] = p;
            end else begin
                e.inst = k;
                e.push = p;
                e.pop  = (p + 1 > last_done[k]) ? p + 1 : last_done[k];
                e.done = e.pop + lat_of(k, cmd);
                e.tag  = tag;
                ref_result(cmd, op1, op2, e.resp, e.data);
                last_done[k] = e.done;
                ent_q.push_back(e);
            end
        end
    endtask

    function automatic bit pending();
        foreach (ent_q[i]) if (ent_q[i].done > cyc) return 1'b1;
        return 1'b0;
    endfunction

    // ------------------------------------------------------ checking
    task automatic cmp(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [1:0]  er, et, ar, at;
            logic [31:0] ed, ad;
            logic        eb, edr, ab, adr;
            er = 2'b00; et = 2'b00; ed = 32'd0; eb = 1'b0;
            foreach (ent_q[i]) begin
                if (ent_q[i].inst == k) begin
                    if (ent_q[i].done == cyc) begin
                        er = ent_q[i].resp; ed = ent_q[i].data; et = ent_q[i].tag;
                    end
                    if (ent_q[i].push <= cyc && ent_q[i].done > cyc) eb = 1'b1;
                end
            end
            edr = (drop_at[k] >= 0) && (drop_at[k] <= cyc);
            if (k == 0) begin
                ar = bus_a.out_resp; ad = bus_a.out_data; at = bus_a.out_tag;
                ab = bus_a.busy;     adr = bus_a.drop_err;
            end else begin
                ar = bus_b.out_resp; ad = bus_b.out_data; at = bus_b.out_tag;
                ab = bus_b.busy;     adr = bus_b.drop_err;
            end
            cmp("resp", k, 32'(ar), 32'(er));
            cmp("data", k, ad, ed);
            cmp("tag", k, 32'(at), 32'(et));
            cmp("busy", k, 32'(ab), 32'(eb));
            cmp("drop_err", k, 32'(adr), 32'(edr));
        end
        for (int i = ent_q.size() - 1; i >= 0; i--)
            if (ent_q[i].done <= cyc) ent_q.delete(i);
    endtask

    // ------------------------------------------------------ driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) model_clear();
        check_outputs();
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] data,
                         input logic [1:0] tag);
        bus_a.req_cmd_in = cmd; bus_a.req_data_in = data; bus_a.req_tag_in = tag;
        bus_b.req_cmd_in = cmd; bus_b.req_data_in = data; bus_b.req_tag_in = tag;
    endtask

    // Command cycle, then op2 cycle carrying a random command that the
    // responder must ignore.
    task automatic send(input logic [3:0] cmd, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [1:0] tag);
        drive(cmd, op1, tag);
        tick();
        drive(4'($urandom_range(0, 15)), op2, 2'($urandom));
        model_add(cmd, op1, op2, tag, cyc + 1);
        tick();
        drive(4'd0, $urandom, 2'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && pending(); i++) tick();
        total++;
        assert (!pending()) else begin
            bad++;
            $error("FAIL drain_timeout cyc=%0d got=pending want=idle", cyc);
        end
    endtask

    // Directed check on dut_a from an idle queue: response at a fixed
    // offset from the command cycle, cleared one cycle later.
    task automatic directed(input string name, input logic [3:0] cmd,
                            input logic [31:0] op1, input logic [31:0] op2,
                            input logic [1:0] tag, input int at,
                            input logic [1:0] er, input logic [31:0] ed);
        int t0;
        t0 = cyc + 1;
        send(cmd, op1, op2, tag);
        while (cyc < t0 + at) tick();
        cmp({name, "_resp"}, 0, 32'(bus_a.out_resp), 32'(er));
        cmp({name, "_data"}, 0, bus_a.out_data, ed);
        cmp({name, "_tag"}, 0, 32'(bus_a.out_tag), 32'(tag));
        tick();
        cmp({name, "_clear"}, 0, 32'(bus_a.out_resp), 32'd0);
        drain();
    endtask

    // ------------------------------------------------------ watchdog
    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------ stimulus
    initial begin
        logic [3:0] cmd_tab [8];
        cmd_tab = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd4, 4'd15};
        model_clear();
        drive(4'd0, 32'd0, 2'd0);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset in the op2 cycle of an ADD: nothing must come back.
        drive(4'd1, 32'h10, 2'd1);
        tick();
        rst = 1'b1;
        drive(4'd0, 32'h20, 2'd0);
        repeat (3) tick();
        rst = 1'b0;
        cmp("rst_busy", 0, 32'(bus_a.busy), 32'd0);
        cmp("rst_state", 0, 32'(dbg_a), 32'd0);
        repeat (8) tick();

        directed("add",     4'd1, 32'h5,         32'h7,  2'd2, 4, 2'b01, 32'hC);
        directed("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'h1,  2'd0, 4, 2'b10, 32'h0);
        directed("sub_neg", 4'd2, 32'h3,         32'h5,  2'd1, 4, 2'b10, 32'h0);
        directed("sub_eq",  4'd2, 32'h5,         32'h5,  2'd1, 4, 2'b01, 32'h0);
        directed("shl",     4'd5, 32'h8000_0001, 32'h21, 2'd0, 5, 2'b01, 32'h2);
        directed("shr",     4'd6, 32'h8000_0000, 32'd31, 2'd2, 5, 2'b01, 32'h1);
        directed("invalid", 4'd4, 32'h1234,      32'h1,  2'd3, 3, 2'b10, 32'h0);

        // Back-to-back shift burst: dut_a keeps up, dut_b loses the sixth.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send(4'd5, $urandom, $urandom, 2'(i % 4));
        drain();
        cmp("burst_drop", 0, 32'(bus_a.drop_err), 32'd0);
        cmp("burst_drop", 1, 32'(bus_b.drop_err), 32'd1);

        // Random traffic with random gaps, including invalid opcodes.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            send(cmd_tab[$urandom_range(0, 7)], a, b, 2'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
